// File: rtl/mcse_ahb_pkg.sv
// Shared types and constants for the MCSE AHB-Lite responder.
//   htrans_e       : AHB transfer type encoding
//   Hresp*         : response encodings (OKAY / ERROR)
//   Hsize*         : transfer size encodings that the responder supports
//   resp_state_e   : responder FSM states
//   byte_strobe()  : byte lanes touched by a transfer of a given size/offset
package mcse_ahb_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_e;

  localparam logic [1:0] HrespOkay  = 2'b00;
  localparam logic [1:0] HrespError = 2'b01;

  localparam logic [2:0] HsizeByte = 3'b000;
  localparam logic [2:0] HsizeHalf = 3'b001;
  localparam logic [2:0] HsizeWord = 3'b010;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } resp_state_e;

  // Little-endian lane select; only called for already-validated sizes.
  function automatic logic [3:0] byte_strobe(logic [2:0] size, logic [1:0] off);
    case (size)
      HsizeByte: byte_strobe = 4'b0001 << off;
      HsizeHalf: byte_strobe = off[1] ? 4'b1100 : 4'b0011;
      default:   byte_strobe = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mcse_ahb_responder_if.sv
// AHB-Lite bus bundle between a requester and the MCSE responder.
//   I_* : requester-driven address/control/write-data and bus-wide ready
//   O_* : responder-driven read data, ready and response
// Modports: slave (responder side), master (requester side).
interface mcse_ahb_responder_if #(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned HrespWidth = 2
);
  logic                  I_hsel;
  logic [AddrWidth-1:0]  I_haddr;
  logic [1:0]            I_htrans;
  logic                  I_hwrite;
  logic [2:0]            I_hsize;
  logic [2:0]            I_hburst;
  logic [3:0]            I_hprot;
  logic                  I_hmastlock;
  logic                  I_hnonsec;
  logic [DataWidth-1:0]  I_hwdata;
  logic                  I_hready;
  logic [DataWidth-1:0]  O_hrdata;
  logic                  O_hreadyout;
  logic [HrespWidth-1:0] O_hresp;

  modport slave (
    input  I_hsel, I_haddr, I_htrans, I_hwrite, I_hsize, I_hburst, I_hprot,
           I_hmastlock, I_hnonsec, I_hwdata, I_hready,
    output O_hrdata, O_hreadyout, O_hresp
  );

  modport master (
    output I_hsel, I_haddr, I_htrans, I_hwrite, I_hsize, I_hburst, I_hprot,
           I_hmastlock, I_hnonsec, I_hwdata, I_hready,
    input  O_hrdata, O_hreadyout, O_hresp
  );
endinterface

// File: rtl/mcse_ahb_resp_mem.sv
// Word storage for the AHB responder: byte-lane write, one asynchronous read
// port sharing the write address, cleared by the asynchronous reset.
//   clk, rst_n : clock, async active-low reset (clears every word)
//   we_i, be_i : write enable and per-byte lane enables
//   addr_i     : word index for both write and read
//   wdata_i    : write data (lane n carries byte n)
//   rdata_o    : current contents of the addressed word
module mcse_ahb_resp_mem #(
  parameter int unsigned Depth = 64,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [Aw-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/mcse_ahb_responder.sv
// AHB-Lite responder serving a word-addressed storage window for the MCSE.
// OKAY transfers take pWAIT_STATES low-ready cycles before the data phase;
// out-of-window, oversized, misaligned or write-protected accesses get the
// two-cycle ERROR response and leave storage untouched.
//   clk, rst_n  : clock, async active-low reset
//   bus         : AHB-Lite slave modport (address/control/data/response)
//   I_wr_lock   : protects words below pLOCK_WORDS from writes
//   O_err_count : saturating count of ERROR responses; built only when
//                 MCSE_RESP_ERR_COUNT_EN is defined, otherwise tied to 0
module mcse_ahb_responder
  import mcse_ahb_pkg::*;
#(
  parameter int unsigned               pAHB_DATA_WIDTH  = 32,
  parameter int unsigned               pAHB_ADDR_WIDTH  = 32,
  parameter int unsigned               pAHB_HRESP_WIDTH = 2,
  parameter int unsigned               pMEM_DEPTH       = 64,
  parameter logic [pAHB_ADDR_WIDTH-1:0] pBASE_ADDR      = 32'h4000_0000,
  parameter int unsigned               pWAIT_STATES     = 1,
  parameter int unsigned               pLOCK_WORDS      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  mcse_ahb_responder_if.slave        bus,
  input  logic                       I_wr_lock,
  output logic [7:0]                 O_err_count
);
  localparam int unsigned WordAw = $clog2(pMEM_DEPTH);
  localparam logic [pAHB_ADDR_WIDTH-1:0] WinBytes  = pAHB_ADDR_WIDTH'(pMEM_DEPTH * 4);
  localparam logic [pAHB_ADDR_WIDTH-1:0] LockBytes = pAHB_ADDR_WIDTH'(pLOCK_WORDS * 4);

  resp_state_e                 state_q, state_d;
  logic [2:0]                  wcnt_q, wcnt_d;
  logic [WordAw-1:0]           word_q;
  logic [1:0]                  boff_q;
  logic                        write_q;
  logic [2:0]                  size_q;
  logic [pAHB_DATA_WIDTH-1:0]  hrdata_q, hrdata_d, mem_rdata;
  logic [pAHB_HRESP_WIDTH-1:0] resp;
  logic [pAHB_ADDR_WIDTH-1:0]  offset;
  logic                        accept, acc_err, mem_we, readyout;

  // Wraps modulo 2^pAHB_ADDR_WIDTH, so addresses below the base land out of window.
  assign offset = bus.I_haddr - pBASE_ADDR;

  // Only states that present hreadyout=1 may take a new address phase.
  assign accept = bus.I_hsel & bus.I_hready & bus.I_htrans[1] &
                  (state_q inside {StIdle, StData, StErr2});

  always_comb begin
    acc_err = 1'b0;
    if (offset >= WinBytes) acc_err = 1'b1;
    if (bus.I_hsize > HsizeWord) acc_err = 1'b1;
    if ((bus.I_hsize == HsizeHalf) && bus.I_haddr[0]) acc_err = 1'b1;
    if ((bus.I_hsize == HsizeWord) && (bus.I_haddr[1:0] != 2'b00)) acc_err = 1'b1;
    // Low words: lifecycle lock blocks all writes, non-secure writes always blocked.
    if (bus.I_hwrite && (offset < LockBytes) && (I_wr_lock || bus.I_hnonsec)) acc_err = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      StWait: begin
        if (wcnt_q <= 3'd1) state_d = StData;
        else                wcnt_d  = wcnt_q - 3'd1;
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
    if (accept) begin
      if (acc_err) begin
        state_d = StErr1;
      end else if (pWAIT_STATES > 0) begin
        state_d = StWait;
        wcnt_d  = 3'(pWAIT_STATES);
      end else begin
        state_d = StData;
      end
    end
  end

  always_comb begin
    readyout = !(state_q inside {StWait, StErr1});
    resp     = (state_q inside {StErr1, StErr2}) ? HrespError : HrespOkay;
    mem_we   = (state_q == StData) && write_q;
    hrdata_d = ((state_q == StData) && !write_q) ? mem_rdata : hrdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      boff_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else if (accept) begin
      word_q  <= offset[WordAw+1:2];
      boff_q  <= offset[1:0];
      write_q <= bus.I_hwrite;
      size_q  <= bus.I_hsize;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hrdata_q <= '0;
    else        hrdata_q <= hrdata_d;
  end

  mcse_ahb_resp_mem #(
    .Depth (pMEM_DEPTH),
    .Aw    (WordAw)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (mem_we),
    .be_i    (byte_strobe(size_q, boff_q)),
    .addr_i  (word_q),
    .wdata_i (bus.I_hwdata),
    .rdata_o (mem_rdata)
  );

  assign bus.O_hrdata    = hrdata_d;
  assign bus.O_hreadyout = readyout;
  assign bus.O_hresp     = resp;

`ifdef MCSE_RESP_ERR_COUNT_EN
  logic [7:0] err_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       err_cnt_q <= '0;
    else if ((state_q == StErr2) && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
  end
  assign O_err_count = err_cnt_q;
`else
  assign O_err_count = 8'h00;
`endif

  // Accepted but intentionally ignored bus fields.
  logic unused_bus;
  assign unused_bus = ^{bus.I_htrans[0], bus.I_hburst, bus.I_hprot, bus.I_hmastlock};
endmodule

// File: tb/tb_mcse_ahb_responder.sv
// Scoreboard bench for mcse_ahb_responder: one instance with one wait state and
// one with zero wait states share the stimulus wires; hsel steers each transfer.
module tb_mcse_ahb_responder;
  localparam logic [31:0] Base = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel = 1'b0, hwrite = 1'b0, hnonsec = 1'b0, wr_lock = 1'b0, use0 = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0, pend_wdata = '0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'd2;
  logic [7:0]  ec0, ec1;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  mcse_ahb_responder_if bus0 ();
  mcse_ahb_responder_if bus1 ();

  assign bus1.I_hsel = hsel & !use0;
  assign bus0.I_hsel = hsel & use0;
  assign hreadyout = use0 ? bus0.O_hreadyout : bus1.O_hreadyout;
  assign hresp     = use0 ? bus0.O_hresp     : bus1.O_hresp;
  assign hrdata    = use0 ? bus0.O_hrdata    : bus1.O_hrdata;
  assign {bus0.I_haddr, bus1.I_haddr}   = {haddr, haddr};
  assign {bus0.I_htrans, bus1.I_htrans} = {htrans, htrans};
  assign {bus0.I_hwrite, bus1.I_hwrite} = {hwrite, hwrite};
  assign {bus0.I_hsize, bus1.I_hsize}   = {hsize, hsize};
  assign {bus0.I_hburst, bus1.I_hburst} = {3'b001, 3'b001};
  assign {bus0.I_hprot, bus1.I_hprot}   = {4'b0011, 4'b0011};
  assign {bus0.I_hmastlock, bus1.I_hmastlock} = 2'b00;
  assign {bus0.I_hnonsec, bus1.I_hnonsec} = {hnonsec, hnonsec};
  assign {bus0.I_hwdata, bus1.I_hwdata} = {hwdata, hwdata};
  assign {bus0.I_hready, bus1.I_hready} = {hreadyout, hreadyout};

  mcse_ahb_responder #(.pWAIT_STATES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .I_wr_lock(wr_lock), .O_err_count(ec1)
  );
  mcse_ahb_responder #(.pWAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .I_wr_lock(wr_lock), .O_err_count(ec0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        rd;
    int          waits;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [2][64];
  int          n_chk = 0, n_err = 0, n_exp_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_ec(input int n);
`ifdef MCSE_RESP_ERR_COUNT_EN
    exp_ec = (n > 255) ? 8'hFF : 8'(n);
`else
    exp_ec = 8'(0 * n);
`endif
  endfunction

  // One bus cycle: present an address phase (or idle) plus the previous write data,
  // then hold it until the cycle completes with hreadyout high.
  task automatic step(input string tag, input logic [1:0] trans, input logic wr,
                      input logic [31:0] addr, input logic [2:0] sz,
                      input logic [31:0] wdata, input logic ns = 1'b0);
    exp_t        e;
    logic [31:0] off, mask;
    logic        err;
    int          sel, guard;
    @(posedge clk); #1;
    hwdata  = pend_wdata;
    hsel    = trans[1];
    htrans  = trans;
    haddr   = addr;
    hwrite  = wr;
    hsize   = sz;
    hnonsec = ns;
    if (trans[1]) begin
      sel = use0 ? 1 : 0;
      off = addr - Base;
      err = (off >= 32'd256) || (sz > 3'd2) || (sz == 3'd1 && addr[0]) ||
            (sz == 3'd2 && addr[1:0] != 2'b00) || (wr && off < 32'd64 && (wr_lock || ns));
      e.resp  = err ? 2'b01 : 2'b00;
      e.waits = err ? 1 : (use0 ? 0 : 1);
      e.rd    = !wr && !err;
      e.tag   = tag;
      e.rdata = '0;
      if (err) begin
        if (!use0) n_exp_err++;
      end else if (wr) begin
        if (sz == 3'd0)      mask = 32'hFF << (8 * addr[1:0]);
        else if (sz == 3'd1) mask = 32'hFFFF << (16 * addr[1]);
        else                 mask = 32'hFFFF_FFFF;
        model[sel][off[7:2]] = (model[sel][off[7:2]] & ~mask) | (wdata & mask);
      end else begin
        e.rdata = model[sel][off[7:2]];
      end
      exp_q.push_back(e);
      pend_wdata = wdata;
    end
    guard = 0;
    @(negedge clk);
    while (!hreadyout && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 20) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic idle();
    step("idle", 2'b00, 1'b0, 32'h0, 3'd2, 32'h0);
  endtask

  // Monitor: follows the AHB pipeline and scores each completed data phase.
  initial begin
    logic       dp_valid;
    int         low_cnt;
    logic [1:0] low_resp;
    exp_t       e;
    dp_valid = 1'b0;
    low_cnt  = 0;
    low_resp = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dp_valid = 1'b0;
        low_cnt  = 0;
      end else begin
        if (dp_valid) begin
          if (!hreadyout) begin
            low_cnt++;
            low_resp = hresp;
          end else if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check({e.tag, "_resp"}, 32'(hresp), 32'(e.resp));
            check({e.tag, "_waits"}, low_cnt, e.waits);
            if (e.resp == 2'b01) check({e.tag, "_err1"}, 32'(low_resp), 32'h1);
            if (e.rd) check({e.tag, "_rdata"}, hrdata, e.rdata);
            low_cnt = 0;
          end
        end
        if (hreadyout) dp_valid = hsel & htrans[1];
      end
    end
  end

  initial begin
    for (int s = 0; s < 2; s++) for (int w = 0; w < 64; w++) model[s][w] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(hreadyout), 32'h1);
    check("rst_resp", 32'(hresp), 32'h0);
    check("rst_rdata", hrdata, 32'h0);
    check("rst_ec1", 32'(ec1), 32'h0);
    rst_n = 1'b1;

    // Word write/read with one wait state.
    step("t1_wr", 2'b10, 1'b1, Base + 32'h40, 3'd2, 32'hDEAD_BEEF);
    idle();
    step("t1_rd", 2'b10, 1'b0, Base + 32'h40, 3'd2, 32'h0);
    idle();

    // Sub-word lanes.
    step("t2_clr", 2'b10, 1'b1, Base + 32'h40, 3'd2, 32'h0);
    step("t2_byte", 2'b10, 1'b1, Base + 32'h43, 3'd0, 32'hA500_0000);
    step("t2_rd", 2'b10, 1'b0, Base + 32'h40, 3'd2, 32'h0);
    step("t2_half", 2'b10, 1'b1, Base + 32'h40, 3'd1, 32'h1111_5A5A);
    step("t2_rd2", 2'b10, 1'b0, Base + 32'h40, 3'd2, 32'h0);
    idle();

    // Error responses, including an accept taken during ERR2.
    step("t3_oow", 2'b10, 1'b0, Base + 32'h100, 3'd2, 32'h0);
    idle();
    idle();
    check("t3_errcnt", 32'(ec1), 32'(exp_ec(n_exp_err)));
    step("t3_mis", 2'b10, 1'b0, Base + 32'h42, 3'd2, 32'h0);
    step("t3_err2acc", 2'b10, 1'b0, Base + 32'h40, 3'd2, 32'h0);
    step("t3_size3", 2'b10, 1'b0, Base + 32'h40, 3'd3, 32'h0);
    step("t3_below", 2'b10, 1'b0, Base - 32'h4, 3'd2, 32'h0);
    step("t3_mishalf", 2'b10, 1'b1, Base + 32'h41, 3'd1, 32'h0);
    step("t3_last", 2'b10, 1'b0, Base + 32'hFC, 3'd2, 32'h0);
    idle();

    // Write protection.
    wr_lock = 1'b1;
    step("t4_lockwr", 2'b10, 1'b1, Base, 3'd2, 32'h0000_1234);
    step("t4_lockrd", 2'b10, 1'b0, Base, 3'd2, 32'h0);
    step("t4_edge", 2'b10, 1'b1, Base + 32'h3C, 3'd0, 32'h7700_0000);
    step("t4_open", 2'b10, 1'b1, Base + 32'h40, 3'd2, 32'hCAFE_F00D);
    idle();
    wr_lock = 1'b0;
    step("t4_unlwr", 2'b10, 1'b1, Base, 3'd2, 32'h0000_1234);
    step("t4_nswr", 2'b10, 1'b1, Base + 32'h8, 3'd2, 32'h5555_5555, 1'b1);
    step("t4_nsrd", 2'b10, 1'b0, Base, 3'd2, 32'h0, 1'b1);
    step("t4_rd8", 2'b10, 1'b0, Base + 32'h8, 3'd2, 32'h0);
    idle();
    idle();
    check("t4_errcnt", 32'(ec1), 32'(exp_ec(n_exp_err)));

    // Zero-wait back-to-back burst.
    use0 = 1'b1;
    for (int i = 0; i < 4; i++)
      step($sformatf("t5_wr%0d", i), (i == 0) ? 2'b10 : 2'b11, 1'b1, Base + 32'h80 + 32'(4 * i),
           3'd2, 32'h1000_0001 * 32'(i + 3));
    for (int i = 0; i < 4; i++)
      step($sformatf("t5_rd%0d", i), (i == 0) ? 2'b10 : 2'b11, 1'b0, Base + 32'h80 + 32'(4 * i),
           3'd2, 32'h0);
    idle();
    idle();
    check("t5_ec0", 32'(ec0), 32'h0);
    use0 = 1'b0;

    // Reset while a write sits in its wait state.
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; haddr = Base + 32'h48; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
    #1;
    check("t6_in_wait", 32'(hreadyout), 32'h0);
    rst_n = 1'b0;
    #1;
    check("t6_ready", 32'(hreadyout), 32'h1);
    check("t6_resp", 32'(hresp), 32'h0);
    check("t6_rdata", hrdata, 32'h0);
    check("t6_ec1", 32'(ec1), 32'h0);
    exp_q.delete();
    for (int s = 0; s < 2; s++) for (int w = 0; w < 64; w++) model[s][w] = '0;
    n_exp_err = 0;
    pend_wdata = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("t6_rd48", 2'b10, 1'b0, Base + 32'h48, 3'd2, 32'h0);
    step("t6_rd40", 2'b10, 1'b0, Base + 32'h40, 3'd2, 32'h0);
    idle();
    use0 = 1'b1;
    step("t6_rd80", 2'b10, 1'b0, Base + 32'h80, 3'd2, 32'h0);
    idle();
    idle();
    use0 = 1'b0;
    check("sb_drain", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
